// File: rtl/hsb_axis_avst_bridge.sv
`default_nettype none
// ============================================================================
// Module   : hsb_axis_avst_bridge
// Brief    : AXI4-Stream sink to Avalon-ST source bridge with FIFO, per-packet
//            byte swap, tkeep checking, error propagation and statistics.
// Revision : 1.0 - initial release
// ============================================================================
module hsb_axis_avst_bridge #(
    parameter int DATA_W       = 64,
    parameter int USER_W       = 1,
    parameter int ERR_USER_BIT = 0,
    parameter int FIFO_DEPTH   = 4,
    parameter int EMPTY_W      = 3,
    parameter int CNT_W        = 32
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        cfg_byte_swap,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    input  logic [DATA_W-1:0]           s_axis_tdata,
    input  logic [DATA_W/8-1:0]         s_axis_tkeep,
    input  logic                        s_axis_tlast,
    input  logic [USER_W-1:0]           s_axis_tuser,
    output logic                        av_src_valid,
    input  logic                        av_src_ready,
    output logic [DATA_W-1:0]           av_src_data,
    output logic                        av_src_startofpacket,
    output logic                        av_src_endofpacket,
    output logic [EMPTY_W-1:0]          av_src_empty,
    output logic                        av_src_error,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    input  logic                        stat_clr,
    output logic [CNT_W-1:0]            stat_pkt_cnt,
    output logic [CNT_W-1:0]            stat_err_cnt,
    output logic [CNT_W-1:0]            stat_stall_max
);

    localparam int KEEP_W = DATA_W / 8;
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = AW + 1;

    typedef struct packed {
        logic [DATA_W-1:0]  data;
        logic [EMPTY_W-1:0] empty;
        logic               eop;
        logic               err;
    } entry_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    entry_t              mem_q [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]    mem_cnt_q, mem_cnt_d, level_d;
    logic                tready_q, tready_d;
    logic                pkt_err_q, pkt_err_d;
    logic                sop_pending_q, sop_pending_d;
    logic                swap_pkt_q, swap_pkt_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [EMPTY_W-1:0]  out_empty_q, out_empty_d;
    logic                out_eop_q, out_eop_d;
    logic                out_err_q, out_err_d;
    logic [CNT_W-1:0]    pkt_cnt_q, pkt_cnt_d, err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0]    stall_run_q, stall_run_d, stall_max_q, stall_max_d;

    entry_t              in_entry, src_entry;
    logic [KEEP_W:0]     keep_inc;
    logic [EMPTY_W-1:0]  zero_cnt;
    logic                keep_viol, beat_err;
    logic                push, pop, out_load, mem_empty, mem_rd, mem_wr, bypass, stall;
    logic [DATA_W-1:0]   src_data_rev;

    // Input beat classification and entry formation
    always_comb begin
        keep_inc = {1'b0, s_axis_tkeep} + (KEEP_W+1)'(1);
        zero_cnt = '0;
        for (int i = 0; i < KEEP_W; i++)
            zero_cnt = zero_cnt + EMPTY_W'(~s_axis_tkeep[i]);
        keep_viol = (s_axis_tkeep == '0)
                  | (!s_axis_tlast && !(&s_axis_tkeep))
                  | (s_axis_tlast && ((keep_inc & {1'b0, s_axis_tkeep}) != '0));
        beat_err  = pkt_err_q | s_axis_tuser[ERR_USER_BIT] | keep_viol;

        in_entry.data  = s_axis_tdata;
        in_entry.empty = s_axis_tlast ? zero_cnt : '0;
        in_entry.eop   = s_axis_tlast;
        in_entry.err   = beat_err;
    end

    // The output register is refilled from the FIFO, or straight from the
    // input when the FIFO is empty, giving single-cycle latency.
    always_comb begin
        push      = s_axis_tvalid && tready_q;
        pop       = out_valid_q && av_src_ready;
        out_load  = !out_valid_q || pop;
        mem_empty = (mem_cnt_q == '0);
        mem_rd    = out_load && !mem_empty;
        bypass    = out_load && mem_empty && push;
        mem_wr    = push && !bypass;
        src_entry = mem_empty ? in_entry : mem_q[rd_ptr_q];
    end

    for (genvar b = 0; b < KEEP_W; b++) begin : g_byte_rev
        assign src_data_rev[8*b +: 8] = src_entry.data[8*(KEEP_W-1-b) +: 8];
    end

    always_comb begin
        wr_ptr_d      = wr_ptr_q + AW'(mem_wr);
        rd_ptr_d      = rd_ptr_q + AW'(mem_rd);
        mem_cnt_d     = mem_cnt_q + LVL_W'(mem_wr) - LVL_W'(mem_rd);
        sop_pending_d = pop ? out_eop_q : sop_pending_q;
        swap_pkt_d    = swap_pkt_q;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        out_empty_d   = out_empty_q;
        out_eop_d     = out_eop_q;
        out_err_d     = out_err_q;
        if (out_load) begin
            out_valid_d = mem_rd || bypass;
            out_empty_d = '0;
            out_eop_d   = 1'b0;
            out_err_d   = 1'b0;
            if (mem_rd || bypass) begin
                // A beat loaded while sop_pending_d is set starts a packet
                if (sop_pending_d)
                    swap_pkt_d = cfg_byte_swap;
                out_data_d  = swap_pkt_d ? src_data_rev : src_entry.data;
                out_empty_d = src_entry.empty;
                out_eop_d   = src_entry.eop;
                out_err_d   = src_entry.err && src_entry.eop;
            end
        end
        level_d  = mem_cnt_d + LVL_W'(out_valid_d);
        tready_d = (level_d < LVL_W'(FIFO_DEPTH));

        pkt_err_d = pkt_err_q;
        if (push)
            pkt_err_d = s_axis_tlast ? 1'b0 : beat_err;

        stall       = s_axis_tvalid && !tready_q;
        stall_run_d = stall ? sat_inc(stall_run_q) : '0;
        pkt_cnt_d   = pkt_cnt_q;
        err_cnt_d   = err_cnt_q;
        stall_max_d = stall_max_q;
        if (stat_clr) begin
            pkt_cnt_d   = '0;
            err_cnt_d   = '0;
            stall_max_d = '0;
        end else begin
            if (pop && out_eop_q) begin
                pkt_cnt_d = sat_inc(pkt_cnt_q);
                if (out_err_q)
                    err_cnt_d = sat_inc(err_cnt_q);
            end
            if (!stall && (stall_run_q > stall_max_q))
                stall_max_d = stall_run_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            mem_cnt_q     <= '0;
            tready_q      <= 1'b0;
            pkt_err_q     <= 1'b0;
            sop_pending_q <= 1'b1;
            swap_pkt_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_empty_q   <= '0;
            out_eop_q     <= 1'b0;
            out_err_q     <= 1'b0;
            pkt_cnt_q     <= '0;
            err_cnt_q     <= '0;
            stall_run_q   <= '0;
            stall_max_q   <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            mem_cnt_q     <= mem_cnt_d;
            tready_q      <= tready_d;
            pkt_err_q     <= pkt_err_d;
            sop_pending_q <= sop_pending_d;
            swap_pkt_q    <= swap_pkt_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_empty_q   <= out_empty_d;
            out_eop_q     <= out_eop_d;
            out_err_q     <= out_err_d;
            pkt_cnt_q     <= pkt_cnt_d;
            err_cnt_q     <= err_cnt_d;
            stall_run_q   <= stall_run_d;
            stall_max_q   <= stall_max_d;
        end
    end

    always_ff @(posedge clk) begin
        if (resetn && mem_wr)
            mem_q[wr_ptr_q] <= in_entry;
    end

    assign s_axis_tready        = tready_q;
    assign av_src_valid         = out_valid_q;
    assign av_src_data          = out_data_q;
    assign av_src_startofpacket = sop_pending_q & out_valid_q;
    assign av_src_endofpacket   = out_eop_q;
    assign av_src_empty         = out_empty_q;
    assign av_src_error         = out_err_q;
    assign fifo_level           = mem_cnt_q + LVL_W'(out_valid_q);
    assign stat_pkt_cnt         = pkt_cnt_q;
    assign stat_err_cnt         = err_cnt_q;
    assign stat_stall_max       = stall_max_q;

endmodule
`default_nettype wire

// File: doc/hsb_axis_avst_bridge.md
Name: hsb_axis_avst_bridge

Overview:
Parametrised AXI4-Stream sink to Avalon-ST source bridge for the HSB datapath. It replaces the fixed two-register skid stage with a configurable-depth FIFO and adds several functions: runtime per-packet byte swap, tkeep validation, error propagation, and SOP/EOP/empty generation. It also provides stall and packet statistics. It sits between HSB AXIS producers and Avalon-ST consumers such as the MIPI/VVP pipeline.

Parameters:
DATA_W, 64, tdata/av data width in bits; multiple of 8, 16..512
USER_W, 1, s_axis_tuser width
ERR_USER_BIT, 0, tuser bit index flagging a bad beat; must be < USER_W
FIFO_DEPTH, 4, FIFO entries; power of 2, >= 2
EMPTY_W, 3, av_src_empty width; must equal clog2(DATA_W/8)
CNT_W, 32, statistics counter width

Ports:
clk  in  1  clock
resetn  in  1  reset
cfg_byte_swap  in  1  1 = reverse byte order on output; sampled per packet
s_axis_tvalid  in  1  AXIS valid
s_axis_tready  out  1  AXIS ready
s_axis_tdata  in  DATA_W  AXIS data, byte 0 = [7:0]
s_axis_tkeep  in  DATA_W/8  AXIS byte enables
s_axis_tlast  in  1  AXIS end of packet
s_axis_tuser  in  USER_W  AXIS sideband
av_src_valid  out  1  Avalon valid
av_src_ready  in  1  Avalon ready (readyLatency 0)
av_src_data  out  DATA_W  Avalon data
av_src_startofpacket  out  1  SOP
av_src_endofpacket  out  1  EOP
av_src_empty  out  EMPTY_W  unused bytes on EOP beat
av_src_error  out  1  packet error, valid on EOP beat only
fifo_level  out  clog2(FIFO_DEPTH)+1  current occupancy
stat_clr  in  1  synchronous clear of stat_* counters
stat_pkt_cnt  out  CNT_W  packets completed on Avalon side, saturating
stat_err_cnt  out  CNT_W  packets sent with av_src_error=1, saturating
stat_stall_max  out  CNT_W  longest run of cycles with tvalid=1 and tready=0, saturating

Behaviour:
- Reset is synchronous and active-low on resetn, clock clk. Reset values:
  - av_src_valid=0, SOP/EOP/error=0, empty=0, s_axis_tready=0.
  - fifo_level=0, all stat_*=0.
  - Internal sop_pending=1, pkt_err=0.
  - s_axis_tready rises on the first cycle after resetn=1.
- Reset mid-packet: FIFO contents are discarded; the partial packet is not terminated downstream; the next accepted beat is treated as SOP.
- Accept: push when s_axis_tvalid && s_axis_tready.
  - s_axis_tready is registered and equals (level < FIFO_DEPTH), computed from next-state level.
  - When full, a pop in the same cycle does not re-enable ready until the following cycle.
- Entry contents: {data, empty, eop=tlast, err}.
  - empty = number of zero bits in tkeep on tlast beats; forced to 0 on non-last beats.
  - keep_violation: any of the following is a violation:
    - non-last beat with tkeep != all ones;
    - last beat with tkeep not contiguous from bit 0 (i.e. tkeep+1 not a power of 2);
    - tkeep == 0.
  - err = pkt_err | tuser[ERR_USER_BIT] | keep_violation.
  - pkt_err becomes sticky on any error beat and clears after the tlast beat is pushed.
- Output: FIFO read side is first-word-fall-through through one output register.
  - Latency is exactly 1 cycle from input accept to av_src_valid when the FIFO is empty.
  - Sustained throughput is 1 beat/clk with av_src_ready=1.
  - av_src_valid holds and all outputs stay stable while av_src_ready=0.
- av_src_startofpacket = sop_pending & av_src_valid.
  - sop_pending is cleared on an output handshake without EOP.
  - sop_pending is set on an output handshake with EOP.
  - A single-beat packet has SOP=EOP=1.
- av_src_error = entry.err & entry.eop. Errors on non-EOP beats are reported only at EOP.
- Byte swap:
  - cfg_byte_swap is latched into swap_pkt when the SOP beat is loaded into the output register.
  - swap_pkt applies to all beats of that packet; mid-packet cfg changes are ignored.
  - When swapping, av_src_data byte i = entry byte (DATA_W/8-1-i). empty is unaffected.
- Statistics:
  - stat_pkt_cnt increments on each EOP handshake; stat_err_cnt increments on EOP handshakes with error=1.
  - stall_run counts consecutive cycles with tvalid=1 && tready=0 and resets to 0 otherwise; stat_stall_max = max(stat_stall_max, stall_run) as the run ends.
  - All counters saturate at 2^CNT_W-1.
  - stat_clr has priority over increments in the same cycle.

Test Plan:
- Single 3-beat packet, tkeep final = 0x3F, av_src_ready=1, cfg_byte_swap=0 -> valid 1 cycle after each accept, SOP on beat0, EOP on beat2, empty=2, error=0, stat_pkt_cnt=1.
- Back-to-back packets (4 beats then 1 beat), cfg_byte_swap=1 with data 0x0706050403020100 -> output 0x0001020304050607; second packet SOP=EOP=1; toggling cfg mid-packet 1 has no effect until packet 2.
- Hold av_src_ready=0 for 10 cycles while tvalid=1, FIFO_DEPTH=4 -> 4 beats accepted, tready=0, fifo_level=4, outputs stable. On release, every beat appears in order with no loss, and stat_stall_max equals the counted stall run.
- tuser[0]=1 on beat 1 of a 4-beat packet; next packet has tkeep=0x0F on a non-last beat, or 0x5F on its last beat -> av_src_error=1 only on the EOP beats of both packets, stat_err_cnt=2, and the following clean packet has error=0.
- resetn pulsed low for 1 cycle mid-packet with 2 entries queued -> av_src_valid=0 and fifo_level=0 the next cycle. tready returns 1 cycle after resetn=1, and the next beat is emitted with SOP=1.
- stat_clr asserted in the same cycle as an EOP handshake -> all stat_* read 0 the next cycle. With CNT_W=4 and 20 packets sent, stat_pkt_cnt saturates at 15.
